// File: rtl/axi_sram_read_slave.sv
// AXI4 read-only slave serving bursts from a single-port SRAM with one cycle of read latency.
// Optional macro SRAM_RD_SLVERR_EN: non-INCR or non-32-bit requests return SLVERR beats with no SRAM access.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module axi_sram_read_slave #(
    parameter int unsigned SRAM_ADDR_BITS = 14
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [`AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]                ARBURST_S,
    input  logic                      ARVALID_S,
    output logic                      ARREADY_S,
    output logic [`AXI_IDS_BITS-1:0]  RID_S,
    output logic [`AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]                RRESP_S,
    output logic                      RLAST_S,
    output logic                      RVALID_S,
    input  logic                      RREADY_S,
    output logic                      SRAM_CEB,
    output logic [SRAM_ADDR_BITS-1:0] SRAM_A,
    input  logic [31:0]               SRAM_DO
);

    localparam int unsigned IDW   = `AXI_IDS_BITS;
    localparam int unsigned AW    = `AXI_ADDR_BITS;
    localparam int unsigned LENW  = `AXI_LEN_BITS;
    localparam int unsigned SIZEW = `AXI_SIZE_BITS;
    localparam int unsigned DW    = `AXI_DATA_BITS;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RESP} state_e;

    state_e                    state_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [IDW-1:0]            rid_q;
    logic [DW-1:0]             rdata_q;
    logic [1:0]                rresp_q;
    logic                      ceb_q;
    logic [SRAM_ADDR_BITS-1:0] sram_a_q;
    logic [IDW-1:0]            id_q;
    logic [LENW-1:0]           len_q;
    logic [LENW-1:0]           beat_q;
    logic                      err_q;

    logic ar_hs_c;
    logic ar_err_c;
    logic unused_ok;

    assign ar_hs_c = ARVALID_S & arready_q;

`ifdef SRAM_RD_SLVERR_EN
    assign ar_err_c = (ARBURST_S != 2'b01) || (ARSIZE_S != SIZEW'(3'b010));
`else
    assign ar_err_c = 1'b0;
`endif

    // Byte lane bits, out-of-SRAM address bits and burst attributes play no part in addressing.
    assign unused_ok = ^{ARADDR_S[1:0], ARADDR_S[AW-1:SRAM_ADDR_BITS+2], ARSIZE_S, ARBURST_S};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            ceb_q     <= 1'b1;
            sram_a_q  <= '0;
            id_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs_c) begin
                        arready_q <= 1'b0;
                        id_q      <= ARID_S;
                        len_q     <= ARLEN_S;
                        beat_q    <= '0;
                        err_q     <= ar_err_c;
                        sram_a_q  <= ARADDR_S[SRAM_ADDR_BITS+1:2];
                        ceb_q     <= ar_err_c;
                        state_q   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    ceb_q   <= 1'b1;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    // SRAM_DO is valid during this cycle, one cycle after the enabled edge.
                    rvalid_q <= 1'b1;
                    rid_q    <= id_q;
                    rdata_q  <= err_q ? '0 : DW'(SRAM_DO);
                    rresp_q  <= err_q ? 2'b10 : 2'b00;
                    rlast_q  <= (beat_q == len_q);
                    state_q  <= RESP;
                end
                RESP: begin
                    if (RREADY_S) begin
                        rvalid_q <= 1'b0;
                        rid_q    <= '0;
                        rdata_q  <= '0;
                        rresp_q  <= 2'b00;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            beat_q   <= beat_q + LENW'(1);
                            sram_a_q <= sram_a_q + SRAM_ADDR_BITS'(1);
                            ceb_q    <= err_q;
                            state_q  <= RD_REQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ARREADY_S = arready_q;
    assign RVALID_S  = rvalid_q;
    assign RLAST_S   = rlast_q;
    assign RID_S     = rid_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rresp_q;
    assign SRAM_CEB  = ceb_q;
    assign SRAM_A    = sram_a_q;

endmodule

// File: tb/tb_axi_sram_read_slave.sv
// Self-checking bench for axi_sram_read_slave: directed and random bursts against a burst-level model.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module tb_axi_sram_read_slave;

    localparam int unsigned SAW   = 14;
    localparam int unsigned WORDS = 16384;

    logic                      ACLK;
    logic                      ARESETn;
    logic [`AXI_IDS_BITS-1:0]  ARID_S;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_S;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_S;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE_S;
    logic [1:0]                ARBURST_S;
    logic                      ARVALID_S;
    logic                      ARREADY_S;
    logic [`AXI_IDS_BITS-1:0]  RID_S;
    logic [`AXI_DATA_BITS-1:0] RDATA_S;
    logic [1:0]                RRESP_S;
    logic                      RLAST_S;
    logic                      RVALID_S;
    logic                      RREADY_S;
    logic                      SRAM_CEB;
    logic [SAW-1:0]            SRAM_A;
    logic [31:0]               SRAM_DO;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]    mem [0:WORDS-1];
    logic [SAW-1:0] acc_q[$];
    int unsigned    exp_acc[$];

    logic [7:0]  cur_id;
    logic [31:0] cur_addr;
    int          cur_len;
    bit          cur_err;

    axi_sram_read_slave #(.SRAM_ADDR_BITS(SAW)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ARID_S    (ARID_S),
        .ARADDR_S  (ARADDR_S),
        .ARLEN_S   (ARLEN_S),
        .ARSIZE_S  (ARSIZE_S),
        .ARBURST_S (ARBURST_S),
        .ARVALID_S (ARVALID_S),
        .ARREADY_S (ARREADY_S),
        .RID_S     (RID_S),
        .RDATA_S   (RDATA_S),
        .RRESP_S   (RRESP_S),
        .RLAST_S   (RLAST_S),
        .RVALID_S  (RVALID_S),
        .RREADY_S  (RREADY_S),
        .SRAM_CEB  (SRAM_CEB),
        .SRAM_A    (SRAM_A),
        .SRAM_DO   (SRAM_DO)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // SRAM model: read data appears after the enabled edge and holds while disabled; log every access.
    always @(posedge ACLK) begin
        if (!SRAM_CEB) begin
            SRAM_DO <= mem[SRAM_A];
            if (ARESETn) acc_q.push_back(SRAM_A);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input bit hold_arv);
        int n;
        @(negedge ACLK);
        cur_id   = id;
        cur_addr = addr;
        cur_len  = len;
`ifdef SRAM_RD_SLVERR_EN
        cur_err  = (burst != 2'b01) || (size != 3'b010);
`else
        cur_err  = 1'b0;
`endif
        exp_acc.delete();
        acc_q.delete();
        ARID_S    = id;
        ARADDR_S  = addr;
        ARLEN_S   = 4'(len);
        ARSIZE_S  = size;
        ARBURST_S = burst;
        ARVALID_S = 1'b1;
        n = 0;
        while (!ARREADY_S && n < 16) begin
            @(negedge ACLK);
            n++;
        end
        check("arready_before_ar", 64'(ARREADY_S), 64'(1));
        @(posedge ACLK);
        #1;
        if (!hold_arv) ARVALID_S = 1'b0;
    endtask

    // One beat: expected word is (start word + beat) modulo the SRAM size.
    task automatic get_beat(input int b, input int stall);
        int          lat;
        bit          seen;
        int unsigned wa;
        logic [31:0] ed;
        logic [1:0]  er;
        wa = ((cur_addr / 4) + b) % WORDS;
        ed = cur_err ? 32'h0 : mem[wa];
        er = cur_err ? 2'b10 : 2'b00;
        if (!cur_err) exp_acc.push_back(wa);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge ACLK);
            lat++;
            if (RVALID_S) seen = 1'b1;
            else check("r_zero_when_invalid", 64'({RID_S, RDATA_S, RRESP_S, RLAST_S}), 64'(0));
        end
        check("beat_latency", 64'(lat), 64'(3));
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge ACLK);
            check("rvalid", 64'(RVALID_S), 64'(1));
            check("rid", 64'(RID_S), 64'(cur_id));
            check("rdata", 64'(RDATA_S), 64'(ed));
            check("rresp", 64'(RRESP_S), 64'(er));
            check("rlast", 64'(RLAST_S), 64'(b == cur_len));
            check("arready_busy", 64'(ARREADY_S), 64'(0));
        end
        if (b == cur_len) ARVALID_S = 1'b0;
        RREADY_S = 1'b1;
        @(posedge ACLK);
        #1;
        RREADY_S = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall0, input int stall_max, input bit hold_arv);
        do_ar(id, addr, len, size, burst, hold_arv);
        for (int b = 0; b <= len; b++)
            get_beat(b, (b == 0) ? stall0 : int'($urandom_range(stall_max, 0)));
        check("sram_access_count", 64'(acc_q.size()), 64'(exp_acc.size()));
        for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
            check("sram_addr", 64'(acc_q[i]), 64'(exp_acc[i]));
        @(negedge ACLK);
        check("arready_after_burst", 64'(ARREADY_S), 64'(1));
        check("rvalid_after_burst", 64'(RVALID_S), 64'(0));
    endtask

    initial begin
        int  n;
        bit  rv_seen;
        ARESETn   = 1'b0;
        ARID_S    = '0;
        ARADDR_S  = '0;
        ARLEN_S   = '0;
        ARSIZE_S  = '0;
        ARBURST_S = '0;
        ARVALID_S = 1'b0;
        RREADY_S  = 1'b0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[16] = 32'hDEADBEEF;

        repeat (3) @(negedge ACLK);
        check("rst_arready", 64'(ARREADY_S), 64'(0));
        check("rst_rvalid", 64'(RVALID_S), 64'(0));
        check("rst_rpayload", 64'({RID_S, RDATA_S, RRESP_S, RLAST_S}), 64'(0));
        check("rst_ceb", 64'(SRAM_CEB), 64'(1));
        check("rst_sram_a", 64'(SRAM_A), 64'(0));
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("arready_after_release", 64'(ARREADY_S), 64'(1));

        // Single beat, 4-beat burst, backpressure, wrap, AR held high during a burst.
        run_burst(8'h12, 32'h0000_0040, 0, 3'b010, 2'b01, 0, 0, 1'b0);
        run_burst(8'h34, 32'h0000_0100, 3, 3'b010, 2'b01, 0, 0, 1'b0);
        run_burst(8'h56, 32'h0000_0200, 1, 3'b010, 2'b01, 5, 0, 1'b0);
        run_burst(8'h78, 32'h0000_FFFC, 1, 3'b010, 2'b01, 0, 0, 1'b0);
        run_burst(8'h9A, 32'h0000_0ABC, 4, 3'b010, 2'b01, 1, 2, 1'b1);
        run_burst(8'hBC, 32'h0000_0300, 2, 3'b010, 2'b10, 0, 1, 1'b0);
        run_burst(8'hCD, 32'h0000_0400, 1, 3'b001, 2'b01, 0, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [2:0] sz;
            logic [1:0] bt;
            sz = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'b010;
            bt = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b01;
            run_burst(8'($urandom), $urandom, int'($urandom_range(15, 0)), sz, bt,
                      int'($urandom_range(3, 0)), 3, 1'($urandom_range(1, 0)));
        end

        // Reset during beat 2 of an 8-beat burst.
        do_ar(8'h5A, 32'h0000_2000, 7, 3'b010, 2'b01, 1'b0);
        get_beat(0, 0);
        get_beat(1, 0);
        n = 0;
        while (!RVALID_S && n < 8) begin
            @(negedge ACLK);
            n++;
        end
        check("beat2_valid_before_reset", 64'(RVALID_S), 64'(1));
        ARESETn = 1'b0;
        #1;
        check("midrst_rvalid", 64'(RVALID_S), 64'(0));
        check("midrst_arready", 64'(ARREADY_S), 64'(0));
        check("midrst_rpayload", 64'({RID_S, RDATA_S, RRESP_S, RLAST_S}), 64'(0));
        check("midrst_ceb", 64'(SRAM_CEB), 64'(1));
        check("midrst_sram_a", 64'(SRAM_A), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        acc_q.delete();
        @(negedge ACLK);
        check("arready_after_midrst", 64'(ARREADY_S), 64'(1));
        rv_seen = 1'b0;
        repeat (10) begin
            @(negedge ACLK);
            if (RVALID_S) rv_seen = 1'b1;
        end
        check("no_residual_beats", 64'(rv_seen), 64'(0));
        check("no_residual_sram", 64'(acc_q.size()), 64'(0));

        run_burst(8'hEE, 32'h0000_0800, 2, 3'b010, 2'b01, 0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_sram_read_slave.md
AXI_SRAM_READ_SLAVE -- requirements
Module: axi_sram_read_slave

Interface
REQ-001 Parameter SRAM_ADDR_BITS, default 14: SRAM word-address width (16K x 32-bit words).
REQ-002 ACLK  input  1  block clock; every register samples on its rising edge.
REQ-003 ARESETn  input  1  reset; asynchronous assertion, active-low.
REQ-004 ARID_S  input  `AXI_IDS_BITS  read transaction ID.
REQ-005 ARADDR_S  input  `AXI_ADDR_BITS  byte start address.
REQ-006 ARLEN_S  input  `AXI_LEN_BITS  beats minus one (0..15).
REQ-007 ARSIZE_S  input  `AXI_SIZE_BITS  beat size code.
REQ-008 ARBURST_S  input  2  burst type.
REQ-009 ARVALID_S  input  1 / ARREADY_S  output  1  AR channel handshake.
REQ-010 RID_S  output  `AXI_IDS_BITS / RDATA_S  output  `AXI_DATA_BITS / RRESP_S  output  2 / RLAST_S  output  1  R channel payload.
REQ-011 RVALID_S  output  1 / RREADY_S  input  1  R channel handshake.
REQ-012 SRAM_CEB  output  1 (active-low enable) / SRAM_A  output  SRAM_ADDR_BITS (word address) / SRAM_DO  input  32 (read data, valid the cycle after the enabled edge, held while CEB=1).

Function
REQ-013 Four states: IDLE, RD_REQ, RD_WAIT, RESP.
REQ-014 IDLE: ARREADY_S=1; an AR handshake (ARVALID_S & ARREADY_S) latches ARID/ARADDR/ARLEN/ARSIZE/ARBURST, clears the beat counter, moves to RD_REQ.
REQ-015 ARREADY_S is 0 in every state except IDLE; one outstanding burst only.
REQ-016 RD_REQ: SRAM_CEB=0, SRAM_A=current byte address [SRAM_ADDR_BITS+1:2]; next state RD_WAIT.
REQ-017 RD_WAIT: SRAM_CEB=1; at the cycle-end edge SRAM_DO is captured into the RDATA register; next state RESP.
REQ-018 RESP: RVALID_S=1, RDATA_S=captured data, RID_S=latched ID, RRESP_S=2'b00 (OKAY), RLAST_S=1 iff beat counter equals latched ARLEN.
REQ-019 All R outputs are stable while RVALID_S=1 and RREADY_S=0 (indefinite backpressure).
REQ-020 RESP with RREADY_S=1: if RLAST_S, go to IDLE; else beat counter +1, address +4, go to RD_REQ.
REQ-021 First-beat latency: RVALID_S rises 3 cycles after the AR handshake edge; each later beat 3 cycles after the prior R handshake.
REQ-022 Address increments are word-aligned (low 2 bits forced to 0 after the first beat) and wrap modulo the SRAM space; no 4KB boundary check.
REQ-023 ARBURST and ARSIZE are ignored for addressing: every beat is INCR, 32-bit.
REQ-024 RID_S, RDATA_S, RRESP_S, RLAST_S are 0 whenever RVALID_S=0.
REQ-025 ARVALID_S asserted during a burst is not accepted until IDLE is re-entered.

Reset
REQ-026 ARESETn=0 immediately forces IDLE and ARREADY_S=0, RVALID_S=0, RLAST_S=0, RID_S=0, RDATA_S=0, RRESP_S=0, SRAM_CEB=1, SRAM_A=0, beat counter 0.
REQ-027 Reset mid-burst abandons the burst; no further beats are emitted after release.
REQ-028 ARREADY_S rises on the first ACLK edge after ARESETn deasserts.

Configuration
REQ-029 Macro SRAM_RD_SLVERR_EN.
REQ-030 Defined: an AR with ARBURST!=2'b01 or ARSIZE!=3'b010 is still accepted and returns ARLEN+1 beats with RRESP_S=2'b10 (SLVERR), RDATA_S=0, no SRAM access (SRAM_CEB stays 1), same per-beat latency.
REQ-031 Undefined: REQ-023 applies; RRESP_S is always 2'b00.

Verification
REQ-032 Single beat: AR ID=8'h12, ADDR=0x40, LEN=0, SRAM word 0x10=0xDEADBEEF -> one beat, RID=8'h12, RDATA=0xDEADBEEF, RLAST=1, RRESP=0, RVALID 3 cycles after AR.
REQ-033 Burst: ADDR=0x100, LEN=3 -> SRAM_A 0x40,0x41,0x42,0x43; four beats; RLAST only on the fourth.
REQ-034 Backpressure: LEN=1, RREADY_S=0 for 5 cycles on beat 0 -> RDATA/RID/RLAST held constant, no new SRAM_CEB pulse until handshake.
REQ-035 Wrap: ADDR=0xFFFC (last word), LEN=1 -> SRAM_A 0x3FFF then 0x0000.
REQ-036 Reset mid-burst: ARESETn low during beat 2 of LEN=7 -> RVALID_S=0 same cycle; after release ARREADY_S=1, no residual beats.
REQ-037 With SRAM_RD_SLVERR_EN: ARBURST=2'b10, LEN=2 -> three beats RRESP=2'b10, RDATA=0, SRAM_CEB never 0.
